// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus responder: FSM encodings and the
// value returned for reads outside the backing RAM.
package mem_bus_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [15:0] MEM_OOR_DATA = 16'h0000;
endpackage

// File: rtl/mem_bus_array.sv
// Backing RAM for the memory bus responder: synchronous write, asynchronous read.
module mem_bus_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  // Contents are deliberately left unreset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side responder for the CPU readM/writeM bus: edge-detects requests,
// waits LATENCY cycles, then holds the response for HOLD cycles.
// Optional sticky protocol-error flag built only with MEM_BUS_ERRCHK_EN.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int HOLD    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              readM,
  input  logic              writeM,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              inputReady,
  output logic              ackOutput,
  output logic              err
);
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_MAX = (LATENCY > HOLD) ? LATENCY : HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAT  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_HOLD = CNT_W'(HOLD - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                rd_q, wr_q, is_wr;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata;
  logic                rd_edge, wr_edge, req, in_range, mem_we;

  assign rd_edge  = readM & ~rd_q;
  assign wr_edge  = writeM & ~wr_q;
  assign req      = rd_edge | wr_edge;
  assign in_range = {1'b0, addr_q} < DEPTH_X;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= readM;
      wr_q <= writeM;
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;

  // One counter serves both the latency wait and the response hold.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          addr_q  <= address;
          wdata_q <= data;
          is_wr   <= wr_edge;
          cnt     <= (LATENCY == 1) ? CNT_HOLD : CNT_LAT;
        end
        ST_WAIT: cnt <= (cnt == '0) ? CNT_HOLD : cnt - CNT_W'(1);
        ST_RESP: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RAM write lands on the first RESP cycle only; out-of-range writes are dropped.
  always_comb begin
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    mem_we     = 1'b0;
    if (state == ST_RESP) begin
      inputReady = ~is_wr;
      ackOutput  = is_wr;
      mem_we     = is_wr & in_range & (cnt == CNT_HOLD);
    end
  end

  assign data = inputReady ? (in_range ? rdata : DATA_W'(MEM_OOR_DATA))
                           : {DATA_W{1'bz}};

  mem_bus_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (rdata)
  );

`ifdef MEM_BUS_ERRCHK_EN
  logic err_q;
  logic addr_bad;
  assign addr_bad = !({1'b0, address} < DEPTH_X);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else if ((state == ST_IDLE && ((rd_edge & wr_edge) | (req & addr_bad))) ||
             (state != ST_IDLE && req))
      err_q <= 1'b1;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule
